// File: rtl/dds_cosine_core.sv
// Phase-accumulator DDS producing a signed 8-bit cosine sample every clock.
// The cosine table is a 65-point quarter-wave ROM folded by the top two phase bits.
module dds_cosine_core #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 8,
    parameter int LUT_AW  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sclr,
    input  logic [PHASE_W-1:0] pinc_in,
    input  logic [PHASE_W-1:0] poff_in,
    output logic [OUT_W-1:0]   cosine,
    output logic [PHASE_W-1:0] phase_out
);

    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] phase_r;
    logic [OUT_W-1:0]   cosine_r;
    logic [PHASE_W-1:0] acc_next_s;
    logic [PHASE_W-1:0] phase_next_s;
    logic [OUT_W-1:0]   cosine_next_s;

    // round(127*cos(k*pi/128)) for k = 0..64
    function automatic logic [7:0] quarter_rom(input logic [6:0] k);
        logic [7:0] v;
        case (k)
            7'd0:  v = 8'd127; 7'd1:  v = 8'd127; 7'd2:  v = 8'd127; 7'd3:  v = 8'd127;
            7'd4:  v = 8'd126; 7'd5:  v = 8'd126; 7'd6:  v = 8'd126; 7'd7:  v = 8'd125;
            7'd8:  v = 8'd125; 7'd9:  v = 8'd124; 7'd10: v = 8'd123; 7'd11: v = 8'd122;
            7'd12: v = 8'd122; 7'd13: v = 8'd121; 7'd14: v = 8'd120; 7'd15: v = 8'd118;
            7'd16: v = 8'd117; 7'd17: v = 8'd116; 7'd18: v = 8'd115; 7'd19: v = 8'd113;
            7'd20: v = 8'd112; 7'd21: v = 8'd111; 7'd22: v = 8'd109; 7'd23: v = 8'd107;
            7'd24: v = 8'd106; 7'd25: v = 8'd104; 7'd26: v = 8'd102; 7'd27: v = 8'd100;
            7'd28: v = 8'd98;  7'd29: v = 8'd96;  7'd30: v = 8'd94;  7'd31: v = 8'd92;
            7'd32: v = 8'd90;  7'd33: v = 8'd88;  7'd34: v = 8'd85;  7'd35: v = 8'd83;
            7'd36: v = 8'd81;  7'd37: v = 8'd78;  7'd38: v = 8'd76;  7'd39: v = 8'd73;
            7'd40: v = 8'd71;  7'd41: v = 8'd68;  7'd42: v = 8'd65;  7'd43: v = 8'd63;
            7'd44: v = 8'd60;  7'd45: v = 8'd57;  7'd46: v = 8'd54;  7'd47: v = 8'd51;
            7'd48: v = 8'd49;  7'd49: v = 8'd46;  7'd50: v = 8'd43;  7'd51: v = 8'd40;
            7'd52: v = 8'd37;  7'd53: v = 8'd34;  7'd54: v = 8'd31;  7'd55: v = 8'd28;
            7'd56: v = 8'd25;  7'd57: v = 8'd22;  7'd58: v = 8'd19;  7'd59: v = 8'd16;
            7'd60: v = 8'd12;  7'd61: v = 8'd9;   7'd62: v = 8'd6;   7'd63: v = 8'd3;
            7'd64: v = 8'd0;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Folding keeps LUT(256-i)=LUT(i) and LUT(128+i)=-LUT(i) exact by construction
    function automatic logic [7:0] cos_lut(input logic [7:0] idx);
        logic [6:0] k;
        logic [6:0] k_mirror;
        logic [7:0] v;
        k        = {1'b0, idx[5:0]};
        k_mirror = 7'd64 - k;
        case (idx[7:6])
            2'd0:    v = quarter_rom(k);
            2'd1:    v = 8'd0 - quarter_rom(k_mirror);
            2'd2:    v = 8'd0 - quarter_rom(k);
            2'd3:    v = quarter_rom(k_mirror);
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Next-state: clear overrides accumulation; phase and cosine use pre-update state
    always_comb begin
        acc_next_s    = acc_r;
        phase_next_s  = phase_r;
        cosine_next_s = cosine_r;
        if (sclr) begin
            acc_next_s    = '0;
            phase_next_s  = '0;
            cosine_next_s = '0;
        end else begin
            acc_next_s    = acc_r + pinc_in;
            phase_next_s  = acc_r + poff_in;
            cosine_next_s = OUT_W'(cos_lut(phase_r[PHASE_W-1 -: LUT_AW]));
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r    <= '0;
            phase_r  <= '0;
            cosine_r <= '0;
        end else begin
            acc_r    <= acc_next_s;
            phase_r  <= phase_next_s;
            cosine_r <= cosine_next_s;
        end
    end

    assign cosine    = cosine_r;
    assign phase_out = phase_r;

endmodule

// File: tb/tb_dds_cosine_core.sv
// Self-checking bench for dds_cosine_core: directed sequences plus randomized
// stimulus against a real-arithmetic cosine reference model.
module tb_dds_cosine_core;

    logic        clk;
    logic        reset_n;
    logic        sclr;
    logic [31:0] pinc_in;
    logic [31:0] poff_in;
    logic [7:0]  cosine;
    logic [31:0] phase_out;

    int checks;
    int errors;

    // Reference state
    logic [31:0] m_acc;
    logic [31:0] m_phase;
    int          m_cos;

    dds_cosine_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclr      (sclr),
        .pinc_in   (pinc_in),
        .poff_in   (poff_in),
        .cosine    (cosine),
        .phase_out (phase_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_lut(input logic [7:0] idx);
        real x;
        x = 127.0 * $cos(2.0 * 3.14159265358979 * real'(int'(idx)) / 256.0);
        if (x >= 0.0) return int'($floor(x + 0.5));
        else return -int'($floor(-x + 0.5));
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset_n || sclr) begin
            m_acc = 32'd0; m_phase = 32'd0; m_cos = 0;
        end else begin
            m_cos   = ref_lut(m_phase[31:24]);
            m_phase = m_acc + poff_in;
            m_acc   = m_acc + pinc_in;
        end
        #1;
    endtask

    task automatic clear_then(input logic [31:0] pinc, input logic [31:0] poff);
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        pinc_in = pinc;
        poff_in = poff;
    endtask

    task automatic test_reset();
        logic [7:0] ec;
        // Initial reset state before any clock edge has been released
        checks++;
        if (cosine !== 8'd0 || phase_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_initial: cosine=%0d phase=%h, required 0 and 0", cosine, phase_out);
        end
        step();
        reset_n = 1'b1;
        pinc_in = 32'h1234_5678;
        poff_in = 32'h0bad_f00d;
        for (int i = 0; i < 6; i++) step();
        ec = 8'(m_cos);
        checks++;
        if (phase_out !== m_phase || cosine !== ec) begin
            errors++;
            $display("FAIL pre_reset_run: cosine=%0d phase=%h, required %0d %h", $signed(cosine), phase_out, $signed(ec), m_phase);
        end
        // Asynchronous assertion mid-cycle, no edge in between
        #2;
        reset_n = 1'b0;
        #1;
        m_acc = 32'd0; m_phase = 32'd0; m_cos = 0;
        checks++;
        if (cosine !== 8'd0 || phase_out !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: cosine=%0d phase=%h, required 0 and 0", cosine, phase_out);
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (phase_out === 32'd0) begin
            errors++;
            $display("FAIL post_reset_run: phase=%h, required nonzero %h", phase_out, m_phase);
        end
        // Synchronous clear zeroes on the edge
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        checks++;
        if (cosine !== 8'd0 || phase_out !== 32'd0) begin
            errors++;
            $display("FAIL sclr_clear: cosine=%0d phase=%h, required 0 and 0", cosine, phase_out);
        end
    endtask

    task automatic test_quarter_rate();
        int exp_c [4] = '{127, 0, -127, 0};
        logic [31:0] ep;
        logic [7:0]  ec;
        clear_then(32'd1073741824, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            step();
            ep = 32'(k - 1) << 30;
            checks++;
            if (phase_out !== ep) begin
                errors++;
                $display("FAIL quarter_phase[%0d]: got %h, required %h", k, phase_out, ep);
            end
            if (k >= 2) begin
                ec = 8'(exp_c[(k - 2) % 4]);
                checks++;
                if (cosine !== ec) begin
                    errors++;
                    $display("FAIL quarter_cos[%0d]: got %0d, required %0d", k, $signed(cosine), $signed(ec));
                end
            end
        end
    endtask

    task automatic test_offset();
        int exp_a [4] = '{0, -127, 0, 127};
        int exp_b [4] = '{-127, 0, 127, 0};
        logic [7:0] ec;
        for (int pass = 0; pass < 2; pass++) begin
            clear_then(32'd1073741824, (pass == 0) ? 32'd1073741824 : 32'd2147483648);
            for (int k = 1; k <= 9; k++) begin
                step();
                if (k >= 2) begin
                    ec = 8'((pass == 0) ? exp_a[(k - 2) % 4] : exp_b[(k - 2) % 4]);
                    checks++;
                    if (cosine !== ec) begin
                        errors++;
                        $display("FAIL offset%0d_cos[%0d]: got %0d, required %0d", pass, k, $signed(cosine), $signed(ec));
                    end
                end
            end
        end
    endtask

    task automatic test_eighth_rate();
        int exp_c [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
        logic [7:0] ec;
        clear_then(32'd536870912, 32'd0);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k >= 2) begin
                ec = 8'(exp_c[(k - 2) % 8]);
                checks++;
                if (cosine !== ec) begin
                    errors++;
                    $display("FAIL eighth_cos[%0d]: got %0d, required %0d", k, $signed(cosine), $signed(ec));
                end
            end
        end
    endtask

    task automatic test_frozen_wrap();
        logic [31:0] ep;
        clear_then(32'd0, 32'hE000_0000);
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (phase_out !== 32'hE000_0000 || (k >= 2 && cosine !== 8'd90)) begin
                errors++;
                $display("FAIL frozen[%0d]: phase=%h cos=%0d, required E0000000 90", k, phase_out, $signed(cosine));
            end
        end
        clear_then(32'hFFFF_FFFF, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            ep = 32'd0 - 32'(k - 1);
            checks++;
            if (phase_out !== ep) begin
                errors++;
                $display("FAIL wrap_phase[%0d]: got %h, required %h", k, phase_out, ep);
            end
        end
    endtask

    task automatic test_dynamic_change();
        logic [31:0] prev;
        logic [31:0] ed;
        clear_then(32'd1073741824, 32'd0);
        step();
        prev = phase_out;
        for (int k = 2; k <= 10; k++) begin
            if (k == 6) pinc_in = 32'd268435456;
            step();
            ed = (k <= 6) ? 32'd1073741824 : 32'd268435456;
            checks++;
            if (phase_out - prev !== ed) begin
                errors++;
                $display("FAIL dynamic_step[%0d]: got %h, required %h", k, phase_out - prev, ed);
            end
            prev = phase_out;
        end
    endtask

    task automatic test_lut_sweep();
        logic [7:0] ec;
        clear_then(32'h0100_0000, 32'd0);
        for (int k = 0; k < 260; k++) begin
            step();
            ec = 8'(m_cos);
            checks++;
            if (cosine !== ec || cosine === 8'h80) begin
                errors++;
                $display("FAIL lut_sweep[%0d]: got %0d, required %0d", k, $signed(cosine), $signed(ec));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ec;
        for (int k = 0; k < 400; k++) begin
            sclr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) pinc_in = $urandom;
            if ($urandom_range(0, 3) == 0) poff_in = $urandom;
            step();
            ec = 8'(m_cos);
            checks++;
            if (phase_out !== m_phase || cosine !== ec) begin
                errors++;
                $display("FAIL random[%0d]: phase=%h cos=%0d, required %h %0d", k, phase_out, $signed(cosine), m_phase, $signed(ec));
            end
        end
        sclr = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        sclr    = 1'b0;
        pinc_in = 32'd0;
        poff_in = 32'd0;
        m_acc   = 32'd0;
        m_phase = 32'd0;
        m_cos   = 0;
        #3;
        test_reset();
        test_quarter_rate();
        test_offset();
        test_eighth_rate();
        test_frozen_wrap();
        test_dynamic_change();
        test_lut_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_cosine_core.md
Name: dds_cosine_core

Overview:
- 32-bit phase-accumulator DDS that outputs an 8-bit signed cosine sample on every clock.
- Frequency is set by a phase-increment word; phase shift is set by a phase-offset word.
- In the fringe-projection path, one sample is produced per display line. Downstream logic converts the signed sample to offset-binary pixel intensity.
- A synchronous clear re-aligns the phase at the start of each frame/row.

Parameters:
- PHASE_W, 32, width of the accumulator, increment, offset and phase_out.
- OUT_W, 8, cosine sample width (signed two's complement).
- LUT_AW, 8, number of phase MSBs used to address the cosine table (256 points per cycle).

Ports:
- clk  input  1  sample clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sclr  input  1  synchronous clear, active-high.
- pinc_in  input  32  phase increment per clock (unsigned).
- poff_in  input  32  phase offset (unsigned; 2^32 = one full cycle).
- cosine  output  8  signed cosine sample.
- phase_out  output  32  registered accumulated phase including offset.

Behaviour:
- State: acc[31:0] (accumulator), phase_reg[31:0] (drives phase_out), cosine_reg[7:0] (drives cosine).
- Reset, asynchronous on reset_n=0: acc=0, phase_reg=0, cosine=0. Outputs hold 0 while reset_n=0.
- Normal operation, each rising clk edge with reset_n=1 and sclr=0:
  - acc <= acc + pinc_in, modulo 2^32; wrap-around is silent.
  - phase_reg <= acc + poff_in, modulo 2^32, using the pre-update acc.
  - cosine_reg <= LUT(phase_reg[31:24]), using the pre-update phase_reg.
- Latency: poff_in change -> phase_out after 1 clk -> cosine after 2 clk. pinc_in change -> first affects phase_out after 2 clk and cosine after 3 clk.
- pinc_in and poff_in are sampled every cycle. No handshake; any change takes effect immediately.
- LUT(i) for i in 0..255 = round(127*cos(2*pi*i/256)), rounding half away from zero, result in -127..+127.
  - The code -128 is never produced.
  - Key values: LUT(0)=127, LUT(32)=90, LUT(64)=0, LUT(96)=-90, LUT(128)=-127, LUT(192)=0, LUT(224)=90.
  - The table may be stored as a full 256-entry ROM or as a quarter-wave ROM folded by i[7:6]. The output must be bit-identical either way.
  - Symmetry must hold exactly: LUT(256-i)=LUT(i) and LUT(128+i)=-LUT(i).
- sclr=1 on a rising edge: acc, phase_reg and cosine_reg all load 0. This overrides accumulation in the same cycle.
  - After sclr deasserts, the sequence restarts exactly as after reset.
- reset_n asserted mid-operation clears everything immediately, without waiting for clk. Release is synchronous to the next edge.
- pinc_in=0: phase is frozen at acc + poff_in, so the output is constant LUT(poff_in[31:24]).
- Increments >= 2^31 are legal: they alias (negative frequency). No saturation.

Test Plan:
- Reset/clear: assert reset_n=0 mid-run -> cosine=0 and phase_out=0 at once, without a clock edge. Pulse sclr=1 for 1 clk -> same zeroing on that edge.
- Quarter-rate: pinc=32'd1073741824, poff=0, from clear -> phase_out = 0, 0x40000000, 0x80000000, 0xC0000000, 0 … on successive clocks. cosine trails phase_out by one clock: 127, 0, -127 (0x81), 0, 127 ….
- Offset: pinc=1073741824, poff=32'd1073741824 -> cosine sequence starts 0, -127, 0, 127. Repeat with poff=2147483648 -> 127 becomes -127 throughout (inverted sequence).
- Eighth-rate: pinc=536870912, poff=0 -> cosine cycles 127, 90, 0, -90, -127, -90, 0, 90 with period 8.
- Wrap/frozen: pinc=0, poff=0xE0000000 -> cosine constant 90 after 2 clk. pinc=0xFFFFFFFF -> phase_out decrements by 1 per clock and wraps from 0 to 0xFFFFFFFF without error.
- Dynamic change: switch pinc from 1073741824 to 268435456 mid-run -> phase_out step size changes exactly 2 clk after the switch, with no glitch or reset of the accumulator.
